// File: rtl/wb_perf_monitor.sv
// Passive multi-port Wishbone performance monitor: per-port transaction,
// beat, first-ack latency, error and busy statistics readable over a small
// Wishbone slave register port.

// Per-port snooper: tracks one monitored bus and keeps its statistics.
module wb_perf_port #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 ack,
    input  logic                 err,
    input  logic                 enable,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] txn,
    output logic [CNT_WIDTH-1:0] beats,
    output logic [CNT_WIDTH-1:0] wait_sum,
    output logic [CNT_WIDTH-1:0] wait_max,
    output logic [CNT_WIDTH-1:0] errs,
    output logic [CNT_WIDTH-1:0] busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    state_t               state, state_nxt;
    logic                 armed;     // cyc has been seen low since reset
    logic [CNT_WIDTH-1:0] lat;
    logic [CNT_WIDTH-1:0] lat_now;   // latency including the current cycle
    logic                 req, term;
    logic                 start, enter_data, abort;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    assign req     = cyc & stb;
    assign term    = req & (ack | err);
    assign lat_now = (state == IDLE) ? CNT_WIDTH'(1) : sat_inc(lat);

    // Next-state and transaction event decode.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        enter_data = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (armed && req) begin
                start = 1'b1;
                if (term) begin
                    state_nxt  = DATA;
                    enter_data = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: if (term) begin
                state_nxt  = DATA;
                enter_data = 1'b1;
            end else if (!cyc) begin
                state_nxt = IDLE;
                abort     = 1'b1;
            end
            DATA: if (!cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus tracking; a cyc still high out of reset must fall before a new transaction.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            armed <= ~cyc;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            armed <= armed | ~cyc;
            if (start || state == WAIT) lat <= lat_now;
        end
    end

    // Saturating statistics; clear beats any same-cycle event.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            txn      <= '0;
            beats    <= '0;
            wait_sum <= '0;
            wait_max <= '0;
            errs     <= '0;
            busy     <= '0;
        end else if (enable) begin
            if (start)                 txn   <= sat_inc(txn);
            if (req && ack)            beats <= sat_inc(beats);
            if ((req && err) || abort) errs  <= sat_inc(errs);
            if (cyc)                   busy  <= sat_inc(busy);
            if (enter_data) begin
                wait_sum <= sat_add(wait_sum, lat_now);
                if (lat_now > wait_max) wait_max <= lat_now;
            end
        end
    end
endmodule

module wb_perf_monitor #(
    parameter int NUM_PORTS = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_PORTS-1:0] mon_cyc_i,
    input  logic [NUM_PORTS-1:0] mon_stb_i,
    input  logic [NUM_PORTS-1:0] mon_ack_i,
    input  logic [NUM_PORTS-1:0] mon_err_i,
    input  logic [7:0]           wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o
);
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] txn_a, beats_a, sum_a, max_a, err_a, busy_a;
    logic        enable;
    logic        clear_q;   // pulses during the ack cycle, applied at its end
    logic        acc;
    logic [4:0]  port_idx;
    logic [31:0] rdata;
    logic        unused_dat;

    assign unused_dat = &{1'b0, wbs_dat_i[31:2]};
    assign acc        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign port_idx   = wbs_adr_i[7:3] - 5'd2;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        wb_perf_port #(.CNT_WIDTH(CNT_WIDTH)) u_port (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .cyc      (mon_cyc_i[g]),
            .stb      (mon_stb_i[g]),
            .ack      (mon_ack_i[g]),
            .err      (mon_err_i[g]),
            .enable   (enable),
            .clear    (clear_q),
            .txn      (txn_a[g]),
            .beats    (beats_a[g]),
            .wait_sum (sum_a[g]),
            .wait_max (max_a[g]),
            .errs     (err_a[g]),
            .busy     (busy_a[g])
        );
    end

    // Register read mux; unmapped words and absent ports read zero.
    always_comb begin
        rdata = '0;
        if (wbs_adr_i == 8'h00) begin
            rdata[0] = enable;
        end else if (wbs_adr_i == 8'h01) begin
            rdata = {16'd0, 8'(CNT_WIDTH), 8'(NUM_PORTS)};
        end else if (wbs_adr_i[7:4] != 4'd0) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_idx == 5'(p)) begin
                    case (wbs_adr_i[2:0])
                        3'd0:    rdata = 32'(txn_a[p]);
                        3'd1:    rdata = 32'(beats_a[p]);
                        3'd2:    rdata = 32'(sum_a[p]);
                        3'd3:    rdata = 32'(max_a[p]);
                        3'd4:    rdata = 32'(err_a[p]);
                        3'd5:    rdata = 32'(busy_a[p]);
                        default: rdata = '0;
                    endcase
                end
            end
        end
    end

    // Slave port: single-cycle ack, CTRL write; a clear write leaves enable alone.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            enable    <= 1'b1;
            clear_q   <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : '0;
            clear_q   <= 1'b0;
            if (acc && wbs_we_i && wbs_adr_i == 8'h00) begin
                if (wbs_dat_i[1]) clear_q <= 1'b1;
                else              enable  <= wbs_dat_i[0];
            end
        end
    end
endmodule

// File: tb/tb_wb_perf_monitor.sv
// Bench for wb_perf_monitor: directed scenarios with literal expectations,
// then randomized bus and register traffic checked against a behavioural model.
module tb_wb_perf_monitor;
    localparam int NP   = 3;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] mcyc, mstb, mack, merr;
    logic [7:0]    adr;
    logic [31:0]   dati, dato;
    logic          we, scyc, sstb, acko;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_perf_monitor #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .mon_cyc_i (mcyc),
        .mon_stb_i (mstb),
        .mon_ack_i (mack),
        .mon_err_i (merr),
        .wbs_adr_i (adr),
        .wbs_dat_i (dati),
        .wbs_we_i  (we),
        .wbs_cyc_i (scyc),
        .wbs_stb_i (sstb),
        .wbs_dat_o (dato),
        .wbs_ack_o (acko)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counters are kept unbounded and clamped on read; every statistic only
    // grows between clears, so clamping equals saturating.
    int       m_cnt[NP][6];   // TXN, BEATS, WAIT_SUM, WAIT_MAX, ERR, BUSY
    bit       m_open[NP], m_got[NP], m_armed[NP];
    int       m_t0[NP];
    int       cyc_no = 0;
    bit       m_en = 1'b1, m_clr = 1'b0, m_ack = 1'b0;
    logic [31:0] m_dat = '0;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int p, r, v;
        if (a == 8'h00) return {31'd0, m_en};
        if (a == 8'h01) return {16'd0, 8'(CW), 8'(NP)};
        if (a < 8'h10) return 32'd0;
        p = (int'(a) - 16) / 8;
        r = (int'(a) - 16) % 8;
        if (p >= NP || r > 5) return 32'd0;
        v = m_cnt[p][r];
        if (v > MAXV) v = MAXV;
        return 32'(v);
    endfunction

    always @(posedge clk) begin : model
        bit acc, req, term, st, ab;
        int lat;
        logic [31:0] nd;
        cyc_no++;
        if (rst) begin
            m_en = 1'b1; m_clr = 1'b0; m_ack = 1'b0; m_dat = '0;
            for (int p = 0; p < NP; p++) begin
                m_open[p] = 1'b0; m_got[p] = 1'b0; m_armed[p] = !mcyc[p];
                for (int r = 0; r < 6; r++) m_cnt[p][r] = 0;
            end
        end else begin
            acc = scyc && sstb && !m_ack;
            nd  = acc ? m_read(adr) : 32'd0;
            for (int p = 0; p < NP; p++) begin
                req  = mcyc[p] && mstb[p];
                term = req && (mack[p] || merr[p]);
                st = 1'b0; ab = 1'b0; lat = 0;
                if (!m_open[p]) begin
                    if (m_armed[p] && req) begin
                        st = 1'b1; m_open[p] = 1'b1; m_got[p] = term; m_t0[p] = cyc_no;
                        if (term) lat = 1;
                    end
                end else if (!m_got[p]) begin
                    if (term) begin
                        m_got[p] = 1'b1; lat = cyc_no - m_t0[p] + 1;
                    end else if (!mcyc[p]) begin
                        m_open[p] = 1'b0; ab = 1'b1;
                    end
                end else if (!mcyc[p]) begin
                    m_open[p] = 1'b0;
                end
                if (m_clr) begin
                    for (int r = 0; r < 6; r++) m_cnt[p][r] = 0;
                end else if (m_en) begin
                    if (st)                    m_cnt[p][0]++;
                    if (req && mack[p])        m_cnt[p][1]++;
                    if (lat > 0) begin
                        m_cnt[p][2] += lat;
                        if (lat > m_cnt[p][3]) m_cnt[p][3] = lat;
                    end
                    if ((req && merr[p]) || ab) m_cnt[p][4]++;
                    if (mcyc[p])               m_cnt[p][5]++;
                end
                m_armed[p] = m_armed[p] || !mcyc[p];
            end
            m_clr = 1'b0;
            if (acc && we && adr == 8'h00) begin
                if (dati[1]) m_clr = 1'b1;
                else         m_en  = dati[0];
            end
            m_ack = acc;
            m_dat = nd;
        end
    end

    // Cycle-by-cycle comparison of the register port against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack", {31'd0, acko}, {31'd0, m_ack});
            if (m_ack) chk("rdata", dato, m_dat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic reg_acc(input logic [7:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] q, output int l);
        @(negedge clk);
        adr = a; we = w; dati = d; scyc = 1'b1; sstb = 1'b1;
        q = '0; l = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (acko) begin
                l = i; q = dato;
                break;
            end
        end
        if (l == 0) begin
            checks++; errors++;
            $display("FAIL reg_timeout adr=0x%0h got=no_ack want=ack", a);
        end
        @(negedge clk);
        scyc = 1'b0; sstb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] q;
        int l;
        reg_acc(a, 1'b0, 32'd0, q, l);
        chk(nm, q, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        int l;
        reg_acc(a, 1'b1, d, q, l);
    endtask

    // lat = cycle (1-based) of the first ack/err; nb beats; e = terminate with err
    task automatic bus_txn(input int p, input int lat, input int nb, input bit e);
        for (int i = 0; i < lat + nb - 1; i++) begin
            @(negedge clk);
            mcyc[p] = 1'b1; mstb[p] = 1'b1;
            mack[p] = (i >= lat - 1) && !e;
            merr[p] = (i >= lat - 1) && e;
        end
        @(negedge clk);
        mcyc[p] = 1'b0; mstb[p] = 1'b0; mack[p] = 1'b0; merr[p] = 1'b0;
    endtask

    task automatic bus_abort(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mcyc[p] = 1'b1; mstb[p] = 1'b1; mack[p] = 1'b0; merr[p] = 1'b0;
        end
        @(negedge clk);
        mcyc[p] = 1'b0; mstb[p] = 1'b0;
    endtask

    function automatic logic [7:0] ra(input int p, input int r);
        return 8'(16 + 8 * p + r);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] q;
        int l;
        rst = 1'b1; mcyc = '0; mstb = '0; mack = '0; merr = '0;
        adr = '0; dati = '0; we = 1'b0; scyc = 1'b0; sstb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, acko}, 32'd0);
        chk("rst_dat", dato, 32'd0);
        rst = 1'b0;

        rd(8'h00, 32'd1, "rst_ctrl");
        rd(ra(0, 0), 32'd0, "rst_txn");
        rd(8'h01, 32'h0803, "info");

        // single read, ack on the 3rd cycle
        bus_txn(0, 3, 1, 1'b0);
        rd(ra(0, 0), 32'd1, "t1_txn");
        rd(ra(0, 1), 32'd1, "t1_beats");
        rd(ra(0, 2), 32'd3, "t1_sum");
        rd(ra(0, 3), 32'd3, "t1_max");
        rd(ra(0, 5), 32'd3, "t1_busy");

        // burst then zero-wait single on port 1
        wr(8'h00, 32'h2);
        bus_txn(1, 5, 4, 1'b0);
        bus_txn(1, 1, 1, 1'b0);
        rd(ra(1, 0), 32'd2, "t2_txn");
        rd(ra(1, 1), 32'd5, "t2_beats");
        rd(ra(1, 2), 32'd6, "t2_sum");
        rd(ra(1, 3), 32'd5, "t2_max");
        rd(ra(1, 5), 32'd9, "t2_busy");
        rd(ra(0, 0), 32'd0, "t2_p0_txn");
        rd(ra(0, 5), 32'd0, "t2_p0_busy");

        // abort then err-terminated single on port 2
        wr(8'h00, 32'h2);
        bus_abort(2, 4);
        bus_txn(2, 1, 1, 1'b1);
        rd(ra(2, 4), 32'd2, "t3_err");
        rd(ra(2, 0), 32'd2, "t3_txn");
        rd(ra(2, 1), 32'd0, "t3_beats");
        rd(ra(2, 2), 32'd1, "t3_sum");

        // saturation
        wr(8'h00, 32'h2);
        for (int i = 0; i < 300; i++) bus_txn(0, 1, 1, 1'b0);
        rd(ra(0, 0), 32'hFF, "t4_txn");
        rd(ra(0, 1), 32'hFF, "t4_beats");
        bus_txn(0, 1, 1, 1'b0);
        rd(ra(0, 0), 32'hFF, "t4_txn_hold");
        rd(ra(0, 5), 32'hFF, "t4_busy_hold");

        // clear write whose ack cycle coincides with a bus ack
        @(negedge clk);
        scyc = 1'b1; sstb = 1'b1; we = 1'b1; adr = 8'h00; dati = 32'h2;
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        @(negedge clk);
        chk("t5_wr_ack", {31'd0, acko}, 32'd1);
        mack[0] = 1'b1;
        @(negedge clk);
        scyc = 1'b0; sstb = 1'b0; we = 1'b0;
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mack[0] = 1'b0;
        rd(ra(0, 0), 32'd0, "t5_txn");
        rd(ra(0, 1), 32'd0, "t5_beats");
        rd(ra(0, 5), 32'd0, "t5_busy");
        rd(8'h00, 32'd1, "t5_ctrl");
        bus_txn(0, 2, 1, 1'b0);
        rd(ra(0, 0), 32'd1, "t5_next_txn");
        rd(ra(0, 2), 32'd2, "t5_next_sum");

        // enable off
        wr(8'h00, 32'h0);
        rd(8'h00, 32'd0, "t6_ctrl_off");
        for (int i = 0; i < 3; i++) bus_txn(0, 2, 1, 1'b0);
        wr(8'h00, 32'h1);
        rd(ra(0, 0), 32'd1, "t6_txn");
        rd(ra(0, 1), 32'd1, "t6_beats");
        reg_acc(8'h7F, 1'b0, 32'd0, q, l);
        chk("t6_7f_data", q, 32'd0);
        chk("t6_7f_lat", 32'(l), 32'd1);
        rd(ra(3, 0), 32'd0, "absent_port");
        rd(ra(0, 6), 32'd0, "reserved_reg");
        wr(ra(0, 0), 32'h55);
        rd(ra(0, 0), 32'd1, "ro_stat");

        // reset in the middle of a transaction, cyc kept high afterwards
        @(negedge clk);
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        bus_txn(1, 2, 1, 1'b0);
        rd(ra(1, 0), 32'd1, "t7_txn");
        rd(ra(1, 4), 32'd0, "t7_err");
        rd(ra(1, 5), 32'd5, "t7_busy");
        rd(ra(1, 2), 32'd2, "t7_sum");

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (it == 1500) rst = 1'b1;
            if (it == 1503) rst = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (mcyc[p]) begin
                    if ($urandom % 6 == 0) mcyc[p] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    mcyc[p] = 1'b1;
                end
                mstb[p] = mcyc[p] && ($urandom % 4 != 0);
                mack[p] = mcyc[p] && ($urandom % 3 == 0);
                merr[p] = mcyc[p] && ($urandom % 12 == 0);
            end
            scyc = ($urandom % 3 != 0);
            sstb = scyc && ($urandom % 4 != 0);
            we   = ($urandom % 16 == 0);
            case ($urandom % 4)
                0:       adr = 8'($urandom % 2);
                3:       adr = 8'($urandom);
                default: adr = 8'(16 + $urandom % 24);
            endcase
            if (we && ($urandom % 2 == 0)) adr = 8'h00;
            case ($urandom % 6)
                0:       dati = 32'h2;
                1:       dati = 32'h0;
                2:       dati = 32'h3;
                default: dati = 32'h1;
            endcase
        end
        @(negedge clk);
        mcyc = '0; mstb = '0; mack = '0; merr = '0;
        scyc = 1'b0; sstb = 1'b0; we = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
